// File: rtl/interconnect_cfg_ctrl_pkg.sv
// Shared definitions for the interconnect configuration sequencer: state
// encoding, switch-code limits and index-width helper.
package interconnect_cfg_ctrl_pkg;

  // Must match the select width of interconnect_unit.
  localparam int SEL_W_DEF   = 6;
  localparam int MAX_SEL_DEF = 39;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RELEASE,
    ST_DONE,
    ST_ERROR
  } cfg_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interconnect_cfg_ctrl_if.sv
// Switch-code stream from the bitstream loader into the configuration
// sequencer: plain valid/ready handshake carrying one code per beat.
interface interconnect_cfg_ctrl_if
  import interconnect_cfg_ctrl_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF
);
  logic             cfg_valid;
  logic [SEL_W-1:0] cfg_data;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/interconnect_cfg_ctrl.sv
// Loads per-input interconnect switch codes, holds the CLB array in program
// mode while loading, then releases the CLBs one per cycle.
module interconnect_cfg_ctrl
  import interconnect_cfg_ctrl_pkg::*;
#(
  parameter int NUM_CLB = 8,
  parameter int LUT_K   = 4,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int MAX_SEL = MAX_SEL_DEF,
  localparam int TOTAL  = NUM_CLB * LUT_K,
  localparam int IDX_W  = idx_width(TOTAL),
  localparam int RC_W   = idx_width(NUM_CLB)
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     cfg_start,
  input  logic                     cfg_abort,
  interconnect_cfg_ctrl_if.slave   cfg,
  output logic [TOTAL*SEL_W-1:0]   switch_bus,
  output logic                     prgm_b,
  output logic [NUM_CLB-1:0]       clb_prgm_b,
  output logic                     cfg_done,
  output logic                     cfg_err,
  output logic [IDX_W-1:0]         err_index
);

  localparam logic [IDX_W-1:0] LAST_W = IDX_W'(TOTAL - 1);
  localparam logic [RC_W-1:0]  LAST_R = RC_W'(NUM_CLB - 1);

  cfg_state_t       state, state_nxt;
  logic [IDX_W-1:0] wcnt;
  logic [RC_W-1:0]  rcnt;
  logic             ready;
  logic [SEL_W-1:0] word;
  logic             accept, bad_word, last_word, abort_now, start_now;

  function automatic logic sel_legal(input logic [SEL_W-1:0] code);
    return code <= SEL_W'(MAX_SEL);
  endfunction

  assign word          = cfg.cfg_data;
  assign cfg.cfg_ready = ready;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bad_word  = 1'b0;
    last_word = 1'b0;
    abort_now = 1'b0;
    start_now = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (cfg_start) begin
          start_now = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Abort outranks a handshake in the same cycle, so the word is dropped.
        if (cfg_abort) begin
          abort_now = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cfg.cfg_valid && ready) begin
          accept = 1'b1;
          if (!sel_legal(word)) begin
            bad_word  = 1'b1;
            state_nxt = ST_ERROR;
          end else if (wcnt == LAST_W) begin
            last_word = 1'b1;
            state_nxt = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        if (cfg_abort) begin
          abort_now = 1'b1;
          state_nxt = ST_IDLE;
        end else if (rcnt == LAST_R) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      switch_bus <= '0;
      prgm_b     <= 1'b0;
      clb_prgm_b <= '1;
      ready      <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
      err_index  <= '0;
      wcnt       <= '0;
      rcnt       <= '0;
    end else if (abort_now) begin
      switch_bus <= '0;
      prgm_b     <= 1'b0;
      clb_prgm_b <= '1;
      ready      <= 1'b0;
      cfg_done   <= 1'b0;
    end else if (start_now) begin
      // Reconfiguration keeps the old codes until each slot is rewritten.
      wcnt       <= '0;
      prgm_b     <= 1'b0;
      clb_prgm_b <= '1;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
      ready      <= 1'b1;
    end else if (accept) begin
      if (bad_word) begin
        err_index <= wcnt;
        cfg_err   <= 1'b1;
        ready     <= 1'b0;
      end else begin
        switch_bus[wcnt*SEL_W +: SEL_W] <= word;
        if (last_word) begin
          ready  <= 1'b0;
          prgm_b <= 1'b1;
          rcnt   <= '0;
        end else begin
          wcnt <= wcnt + 1'b1;
        end
      end
    end else if (state == ST_RELEASE) begin
      clb_prgm_b[rcnt] <= 1'b0;
      if (rcnt == LAST_R) cfg_done <= 1'b1;
      else                rcnt     <= rcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_interconnect_cfg_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a transaction-level model of the configuration sequence.
module tb_interconnect_cfg_ctrl;
  import interconnect_cfg_ctrl_pkg::*;

  localparam int NUM_CLB = 8;
  localparam int LUT_K   = 4;
  localparam int SEL_W   = 6;
  localparam int MAX_SEL = 39;
  localparam int TOTAL   = NUM_CLB * LUT_K;
  localparam int IDX_W   = $clog2(TOTAL);
  localparam int BUS_W   = TOTAL * SEL_W;

  localparam int M_IDLE = 0, M_LOAD = 1, M_REL = 2, M_ERR = 3;

  typedef logic [BUS_W-1:0] wide_t;

  logic               clk = 1'b0;
  logic               rst_b = 1'b1;
  logic               cfg_start = 1'b0;
  logic               cfg_abort = 1'b0;
  wide_t              switch_bus;
  logic               prgm_b;
  logic [NUM_CLB-1:0] clb_prgm_b;
  logic               cfg_done;
  logic               cfg_err;
  logic [IDX_W-1:0]   err_index;

  interconnect_cfg_ctrl_if #(.SEL_W(SEL_W)) cfg_bus();

  interconnect_cfg_ctrl #(
    .NUM_CLB(NUM_CLB), .LUT_K(LUT_K), .SEL_W(SEL_W), .MAX_SEL(MAX_SEL)
  ) dut (
    .clk(clk), .rst_b(rst_b), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg(cfg_bus), .switch_bus(switch_bus), .prgm_b(prgm_b),
    .clb_prgm_b(clb_prgm_b), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .err_index(err_index)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: mode REL covers both releasing and done; the release timeline is
  // derived from m_l, the cycle in which the final word was accepted.
  int m_mode, m_n, m_l, m_err_idx;
  int m_slot[TOTAL];
  wide_t ref_bus;

  task automatic chk(input string name, input wide_t act, input wide_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_n = 0; m_l = 0; m_err_idx = 0;
    for (int i = 0; i < TOTAL; i++) m_slot[i] = 0;
  endtask

  task automatic model_edge();
    int c;
    logic releasing;
    c = cyc;
    if (!rst_b) begin
      model_reset();
      return;
    end
    releasing = (m_mode == M_REL) && (c < m_l + 1 + NUM_CLB);
    case (m_mode)
      M_IDLE: if (cfg_start) begin m_mode = M_LOAD; m_n = 0; end
      M_LOAD: begin
        if (cfg_abort) begin
          m_mode = M_IDLE;
          for (int i = 0; i < TOTAL; i++) m_slot[i] = 0;
        end else if (cfg_bus.cfg_valid) begin
          if (int'(cfg_bus.cfg_data) > MAX_SEL) begin
            m_mode = M_ERR; m_err_idx = m_n;
          end else begin
            m_slot[m_n] = int'(cfg_bus.cfg_data);
            m_n++;
            if (m_n == TOTAL) begin m_mode = M_REL; m_l = c; end
          end
        end
      end
      M_REL: begin
        if (releasing) begin
          if (cfg_abort) begin
            m_mode = M_IDLE;
            for (int i = 0; i < TOTAL; i++) m_slot[i] = 0;
          end
        end else if (cfg_start) begin
          m_mode = M_LOAD; m_n = 0;
        end
      end
      default: if (cfg_start) begin m_mode = M_LOAD; m_n = 0; end
    endcase
  endtask

  task automatic compare_all();
    logic [NUM_CLB-1:0] e_clb;
    wide_t e_bus;
    logic rel;
    rel = (m_mode == M_REL);
    for (int k = 0; k < NUM_CLB; k++) e_clb[k] = !(rel && cyc >= m_l + 2 + k);
    for (int n = 0; n < TOTAL; n++) e_bus[n*SEL_W +: SEL_W] = SEL_W'(m_slot[n]);
    chk("cfg_ready",  wide_t'(cfg_bus.cfg_ready), wide_t'(m_mode == M_LOAD));
    chk("prgm_b",     wide_t'(prgm_b),            wide_t'(rel));
    chk("clb_prgm_b", wide_t'(clb_prgm_b),        wide_t'(e_clb));
    chk("cfg_done",   wide_t'(cfg_done),          wide_t'(rel && cyc >= m_l + 1 + NUM_CLB));
    chk("cfg_err",    wide_t'(cfg_err),           wide_t'(m_mode == M_ERR));
    chk("err_index",  wide_t'(err_index),         wide_t'(m_err_idx));
    chk("switch_bus", switch_bus,                 e_bus);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
  endtask

  task automatic send(input int v);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_data  = SEL_W'(v);
    tick();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !cfg_done; i++) tick();
    chk("done_within_bound", wide_t'(cfg_done), wide_t'(1));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_prgm_b"},  wide_t'(prgm_b),            wide_t'(0));
    chk({tag, "_clb"},     wide_t'(clb_prgm_b),        wide_t'(8'hFF));
    chk({tag, "_bus"},     switch_bus,                 wide_t'(0));
    chk({tag, "_ready"},   wide_t'(cfg_bus.cfg_ready), wide_t'(0));
    chk({tag, "_done"},    wide_t'(cfg_done),          wide_t'(0));
    chk({tag, "_err"},     wide_t'(cfg_err),           wide_t'(0));
    chk({tag, "_err_idx"}, wide_t'(err_index),         wide_t'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    logic [SEL_W-1:0] slot;
    model_reset();
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_data  = '0;
    for (int n = 0; n < TOTAL; n++) ref_bus[n*SEL_W +: SEL_W] = SEL_W'(n % 40);

    #1 rst_b = 1'b0;
    #1 chk_reset_values("reset");
    tick(); tick();
    rst_b = 1'b1;
    tick();

    // Back-to-back load of n%40 and the release timeline after it.
    pulse_start();
    for (int n = 0; n < TOTAL; n++) send(n % 40);
    chk("L1_prgm_b", wide_t'(prgm_b), wide_t'(1));
    chk("L1_clb", wide_t'(clb_prgm_b), wide_t'(8'hFF));
    chk("L1_bus", switch_bus, ref_bus);
    tick();
    chk("L2_clb", wide_t'(clb_prgm_b), wide_t'(8'hFE));
    repeat (6) tick();
    chk("L8_clb", wide_t'(clb_prgm_b), wide_t'(8'h80));
    chk("L8_done", wide_t'(cfg_done), wide_t'(0));
    tick();
    chk("L9_clb", wide_t'(clb_prgm_b), wide_t'(8'h00));
    chk("L9_done", wide_t'(cfg_done), wide_t'(1));

    // Reconfigure from DONE with a gap after every word.
    pulse_start();
    chk("reload_prgm_b", wide_t'(prgm_b), wide_t'(0));
    chk("reload_clb", wide_t'(clb_prgm_b), wide_t'(8'hFF));
    for (int n = 0; n < TOTAL; n++) begin
      send(n % 40);
      tick();
    end
    wait_done();
    chk("gapped_bus", switch_bus, ref_bus);

    // Reconfigure with the highest legal code everywhere.
    pulse_start();
    for (int n = 0; n < TOTAL; n++) send(39);
    wait_done();
    chk("all39_bus", switch_bus, {TOTAL{6'd39}});

    // Illegal code on word 5.
    pulse_start();
    for (int n = 0; n < 5; n++) send(1);
    send(40);
    chk("err_flag", wide_t'(cfg_err), wide_t'(1));
    chk("err_index5", wide_t'(err_index), wide_t'(5));
    chk("err_ready", wide_t'(cfg_bus.cfg_ready), wide_t'(0));
    slot = switch_bus[5*SEL_W +: SEL_W];
    chk("slot5_kept", wide_t'(slot), wide_t'(39));
    tick(); tick();
    pulse_start();
    chk("restart_err", wide_t'(cfg_err), wide_t'(0));
    chk("restart_ready", wide_t'(cfg_bus.cfg_ready), wide_t'(1));
    send(12);
    slot = switch_bus[0 +: SEL_W];
    chk("restart_slot0", wide_t'(slot), wide_t'(12));

    // Abort together with a valid word 10.
    for (int n = 1; n < 10; n++) send(20 + n);
    cfg_abort = 1'b1;
    send(7);
    cfg_abort = 1'b0;
    chk("abort_load_bus", switch_bus, wide_t'(0));
    chk("abort_load_ready", wide_t'(cfg_bus.cfg_ready), wide_t'(0));
    tick();

    // Abort during release after CLB 3 is released.
    pulse_start();
    for (int n = 0; n < TOTAL; n++) send(n % 40);
    repeat (4) tick();
    chk("rel_clb_before_abort", wide_t'(clb_prgm_b), wide_t'(8'hF0));
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    chk("abort_rel_clb", wide_t'(clb_prgm_b), wide_t'(8'hFF));
    chk("abort_rel_prgm_b", wide_t'(prgm_b), wide_t'(0));
    chk("abort_rel_bus", switch_bus, wide_t'(0));

    // Asynchronous reset while word 17 is on the bus.
    pulse_start();
    for (int n = 0; n < 17; n++) send(n);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_data  = SEL_W'(17);
    #2 rst_b = 1'b0;
    #1 chk_reset_values("midload_reset");
    model_reset();
    cfg_bus.cfg_valid = 1'b0;
    tick();
    rst_b = 1'b1;
    tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cfg_start         = ($urandom_range(0, 19) == 0);
      cfg_abort         = ($urandom_range(0, 149) == 0);
      cfg_bus.cfg_valid = ($urandom_range(0, 2) != 0);
      cfg_bus.cfg_data  = ($urandom_range(0, 63) == 0) ? SEL_W'($urandom_range(40, 63))
                                                       : SEL_W'($urandom_range(0, 39));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
